// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: default geometry and the arbiter grant encoding.
// Used by the arbiter, the address translator and the capture path.
package fb_pkg;

  localparam int FB_DEFAULT_ADDR_BITS = 15;
  localparam int FB_DEFAULT_DATA_BITS = 12;    // RGB444
  localparam int FB_DEFAULT_DEPTH     = 19200; // 160x120 words

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } grant_e;

endpackage

// File: rtl/fb_wfifo.sv
// Small synchronous write buffer for the frame-buffer arbiter.
// It ignores a push when full and a pop when empty, so callers may assert either freely.
module fb_wfifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap for free because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers define validity, and this keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: display reads take strict priority over buffered capture writes.
// It issues one registered RAM access per cycle and returns read data three cycles after the request.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_BITS   = FB_DEFAULT_ADDR_BITS,
  parameter int DATA_BITS   = FB_DEFAULT_DATA_BITS,
  parameter int FB_DEPTH    = FB_DEFAULT_DEPTH,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_req,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 wr_req,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_ready,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 ovf,
  output logic                 oor,
  input  logic                 err_clr
);

  localparam int CW  = $clog2(WFIFO_DEPTH) + 1;
  localparam int EW  = ADDR_BITS + DATA_BITS;
  localparam int AW1 = ADDR_BITS + 1;
  localparam logic [AW1-1:0] DEPTH_LIM = AW1'(FB_DEPTH);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(WFIFO_DEPTH);

  logic                 rd_in_range;
  logic                 wr_in_range;
  logic                 rd_grant;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [EW-1:0]        fifo_head;
  logic [ADDR_BITS-1:0] head_addr;
  logic [DATA_BITS-1:0] head_data;
  logic                 ovf_set;
  logic                 oor_set;
  grant_e               gnt_next;
  grant_e               gnt_q;
  logic                 rd_p1, rd_p1_oor;
  logic                 rd_p2, rd_p2_oor;

  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);
  assign rd_grant    = rd_req & rd_in_range;

  assign wr_ready  = (fifo_count != FULL_CNT);
  assign fifo_push = wr_req & wr_ready & wr_in_range;
  assign fifo_pop  = (gnt_next == GNT_WR);
  assign {head_addr, head_data} = fifo_head;

  // Out-of-range writes are still "accepted" (consumed) but never reach the buffer.
  assign ovf_set = wr_req & fifo_full;
  assign oor_set = (rd_req & ~rd_in_range) | (wr_req & wr_ready & ~wr_in_range);

  fb_wfifo #(
    .WIDTH (EW),
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({wr_addr, wr_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // NOTE: the default assignment first means every path drives gnt_next, so no latch is inferred.
  always_comb begin
    gnt_next = GNT_IDLE;
    if (rd_grant)         gnt_next = GNT_RD;
    else if (!fifo_empty) gnt_next = GNT_WR;
  end

  // Grant decided this cycle drives the RAM next cycle; address holds while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q     <= GNT_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      gnt_q <= gnt_next;
      case (gnt_next)
        GNT_RD: mem_addr <= rd_addr;
        GNT_WR: begin
          mem_addr  <= head_addr;
          mem_wdata <= head_data;
        end
        default: ;
      endcase
    end
  end

  assign mem_we = (gnt_q == GNT_WR);

  // Every request, in range or not, returns a word so display timing is preserved.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_p1     <= 1'b0;
      rd_p1_oor <= 1'b0;
      rd_p2     <= 1'b0;
      rd_p2_oor <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_p1     <= rd_req;
      rd_p1_oor <= ~rd_in_range;
      rd_p2     <= rd_p1;
      rd_p2_oor <= rd_p1_oor;
      rd_valid  <= rd_p2;
      if (rd_p2) rd_data <= rd_p2_oor ? '0 : mem_rdata;
    end
  end

  // Sticky flags: a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      oor <= 1'b0;
    end else begin
      ovf <= (ovf & ~err_clr) | ovf_set;
      oor <= (oor & ~err_clr) | oor_set;
    end
  end

endmodule
